// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer; SEQ_EARLY_END_EN selects per-opcode instruction length
module control_sequencer #(
    parameter int STEP_W   = 3,
    parameter int MAX_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic [3:0]        opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [15:0]       ctrl,
    output logic [STEP_W-1:0] step,
    output logic              instr_done,
    output logic              halted
);
    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

    localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] last_step;
    logic              halted_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= '0;
            halted <= 1'b0;
        end else begin
            step   <= step_d;
            halted <= halted_d;
        end
    end

`ifdef SEQ_EARLY_END_EN
    always_comb begin
        case (opcode)
            4'h1, 4'h4:                             last_step = T3;
            4'h2, 4'h3:                             last_step = T4;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF:     last_step = T2;
            default:                                last_step = T1;
        endcase
    end
`else
    assign last_step = STEP_W'(MAX_STEP);
`endif

    // HLT at T2 freezes the counter instead of advancing it
    always_comb begin
        step_d   = step;
        halted_d = halted;
        if (step_en && !halted) begin
            if (step == T2 && opcode == 4'hF)
                halted_d = 1'b1;
            else if (step == last_step)
                step_d = '0;
            else
                step_d = step + 1'b1;
        end
    end

    assign instr_done = !halted && (step == last_step);

    always_comb begin
        ctrl = 16'h0000;
        if (halted) begin
            ctrl = HLT;
        end else if (step == T0) begin
            ctrl = CO | MI;
        end else if (step == T1) begin
            ctrl = RO | II | CE;
        end else begin
            case (opcode)
                4'h1: begin
                    if (step == T2)      ctrl = IO | MI;
                    else if (step == T3) ctrl = RO | AI;
                end
                4'h2: begin
                    if (step == T2)      ctrl = IO | MI;
                    else if (step == T3) ctrl = RO | BI;
                    else if (step == T4) ctrl = EO | AI | FI;
                end
                4'h3: begin
                    if (step == T2)      ctrl = IO | MI;
                    else if (step == T3) ctrl = RO | BI;
                    else if (step == T4) ctrl = EO | AI | SU | FI;
                end
                4'h4: begin
                    if (step == T2)      ctrl = IO | MI;
                    else if (step == T3) ctrl = AO | RI;
                end
                4'h5: if (step == T2) ctrl = IO | AI;
                4'h6: if (step == T2) ctrl = IO | J;
                4'h7: if (step == T2) ctrl = IO | (carry_flag ? J : 16'h0000);
                4'h8: if (step == T2) ctrl = IO | (zero_flag ? J : 16'h0000);
                4'hE: if (step == T2) ctrl = AO | OI;
                4'hF: if (step == T2) ctrl = HLT;
                default: ctrl = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_en = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        instr_done;
    logic        halted;

    typedef struct packed {
        logic [2:0]  step;
        logic [15:0] ctrl;
        logic        done;
        logic        halted;
    } obs_t;

    obs_t exp_q[$];
    obs_t e;
    obs_t g;
    int   total  = 0;
    int   passed = 0;

`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    control_sequencer #(.STEP_W(3), .MAX_STEP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_en    (step_en),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (ctrl),
        .step       (step),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] last_of(input logic [3:0] op);
        if (!EARLY) return 3'd4;
        case (op)
            4'h1, 4'h4:                         return 3'd3;
            4'h2, 4'h3:                         return 3'd4;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3'd2;
            default:                            return 3'd1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step_en = 1'b1; opcode = 4'h0;
        tick();
        tick();
        exp_q.push_back({3'd0, 16'h4004, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                rst = 1'b0;
                #1;
                exp_q.push_back({3'd0, 16'h4004, 1'b0, 1'b0});
            end
            if (k == 2) begin
                tick();
                exp_q.push_back({3'd1, 16'h1408, last_of(4'h0) == 3'd1, 1'b0});
            end
            g = {step, ctrl, instr_done, halted};
            e = exp_q.pop_front();
            total++;
            if (g !== e) $display("FAIL reset[%0d]: got step=%0d ctrl=%h done=%b halted=%b, want step=%0d ctrl=%h done=%b halted=%b",
                                  k, g.step, g.ctrl, g.done, g.halted, e.step, e.ctrl, e.done, e.halted);
            else passed++;
        end
    endtask

    task automatic test_add();
        logic [15:0] tab [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281};
        do_reset();
        opcode = 4'h2;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back({3'(i), tab[i], i == 4, 1'b0});
            else       exp_q.push_back({3'd0, 16'h4004, 1'b0, 1'b0});
            g = {step, ctrl, instr_done, halted};
            e = exp_q.pop_front();
            total++;
            if (g !== e) $display("FAIL add[%0d]: got step=%0d ctrl=%h done=%b halted=%b, want step=%0d ctrl=%h done=%b halted=%b",
                                  i, g.step, g.ctrl, g.done, g.halted, e.step, e.ctrl, e.done, e.halted);
            else passed++;
            tick();
        end
    endtask

    task automatic test_cond_jump();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin
                    do_reset();
                    opcode = 4'h7; carry_flag = 1'b1;
                    tick();
                    exp_q.push_back({3'd1, 16'h1408, 1'b0, 1'b0});
                end
                1: begin
                    carry_flag = 1'b0;
                    tick();
                    exp_q.push_back({3'd2, 16'h0800, last_of(4'h7) == 3'd2, 1'b0});
                end
                2: begin
                    carry_flag = 1'b1;
                    #1;
                    exp_q.push_back({3'd2, 16'h0802, last_of(4'h7) == 3'd2, 1'b0});
                end
                default: begin
                    carry_flag = 1'b0;
                    do_reset();
                    opcode = 4'h8; zero_flag = 1'b1;
                    tick();
                    tick();
                    exp_q.push_back({3'd2, 16'h0802, last_of(4'h8) == 3'd2, 1'b0});
                end
            endcase
            g = {step, ctrl, instr_done, halted};
            e = exp_q.pop_front();
            total++;
            if (g !== e) $display("FAIL cond_jump[%0d]: got step=%0d ctrl=%h done=%b halted=%b, want step=%0d ctrl=%h done=%b halted=%b",
                                  k, g.step, g.ctrl, g.done, g.halted, e.step, e.ctrl, e.done, e.halted);
            else passed++;
        end
        zero_flag = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        opcode = 4'hF;
        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                exp_q.push_back({3'd2, 16'h8000, last_of(4'hF) == 3'd2, 1'b0});
            end else if (i < 12) begin
                tick();
                exp_q.push_back({3'd2, 16'h8000, 1'b0, 1'b1});
            end else begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp_q.push_back({3'd0, 16'h4004, 1'b0, 1'b0});
            end
            g = {step, ctrl, instr_done, halted};
            e = exp_q.pop_front();
            total++;
            if (g !== e) $display("FAIL halt[%0d]: got step=%0d ctrl=%h done=%b halted=%b, want step=%0d ctrl=%h done=%b halted=%b",
                                  i, g.step, g.ctrl, g.done, g.halted, e.step, e.ctrl, e.done, e.halted);
            else passed++;
        end
        opcode = 4'h0;
    endtask

    task automatic test_stall();
        do_reset();
        opcode = 4'h1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                step_en = 1'b0;
            end else if (i < 4) begin
                tick();
            end else begin
                step_en = 1'b1;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            if (i < 4) exp_q.push_back({3'd3, 16'h1200, last_of(4'h1) == 3'd3, 1'b0});
            else       exp_q.push_back({3'd0, 16'h4004, 1'b0, 1'b0});
            g = {step, ctrl, instr_done, halted};
            e = exp_q.pop_front();
            total++;
            if (g !== e) $display("FAIL stall[%0d]: got step=%0d ctrl=%h done=%b halted=%b, want step=%0d ctrl=%h done=%b halted=%b",
                                  i, g.step, g.ctrl, g.done, g.halted, e.step, e.ctrl, e.done, e.halted);
            else passed++;
        end
    endtask

    task automatic test_back_to_back(input logic [3:0] op, input logic [15:0] t2, input string name);
        int          n;
        logic [2:0]  s;
        logic [15:0] c;
        do_reset();
        opcode = op;
        n = int'(last_of(op)) + 1;
        for (int i = 0; i <= 2 * n; i++) begin
            s = 3'(i % n);
            c = (s == 3'd0) ? 16'h4004 : (s == 3'd1) ? 16'h1408 : (s == 3'd2) ? t2 : 16'h0000;
            exp_q.push_back({s, c, s == last_of(op), 1'b0});
            g = {step, ctrl, instr_done, halted};
            e = exp_q.pop_front();
            total++;
            if (g !== e) $display("FAIL %s[%0d]: got step=%0d ctrl=%h done=%b halted=%b, want step=%0d ctrl=%h done=%b halted=%b",
                                  name, i, g.step, g.ctrl, g.done, g.halted, e.step, e.ctrl, e.done, e.halted);
            else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cond_jump();
        test_halt();
        test_stall();
        test_back_to_back(4'h5, 16'h0A00, "ldi");
        test_back_to_back(4'h0, 16'h0000, "nop");
        test_back_to_back(4'hB, 16'h0000, "undef");
        test_back_to_back(4'hE, 16'h0110, "out");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
